// File: rtl/mem_arbiter_pkg.sv
// Shared constants and encodings for the IF/MEM data-RAM arbiter.
package mem_arbiter_pkg;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between IF and MEM with a bounded MEM streak so a
// continuously requesting MEM stage cannot starve instruction fetch.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic mem_req,
    input  logic grant_en,
    output logic grant_if,
    output logic grant_mem
);

    localparam int STREAK_W = cnt_width(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;

    assign grant_mem = grant_en & mem_req & (~if_req | (streak_q < STREAK_MAX));
    assign grant_if  = grant_en & if_req & ~grant_mem;

    // Streak counts only MEM grants that left IF waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else if (grant_mem && if_req) begin
            if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end else if (grant_mem || grant_if) begin
            streak_q <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data RAM between instruction fetch and load/store,
// holding the RAM for RAM_LAT cycles per access and acking with a 1-cycle pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_ack,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_sel,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                stallreq_if,
    output logic                stallreq_mem,
    output logic [1:0]          dbg_state
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = cnt_width(RAM_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

    state_e             state_q, state_d;
    owner_e             owner_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [SEL_W-1:0]   sel_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               grant_en, grant_if, grant_mem;

    assign grant_en = (state_q == ST_IDLE);

    mem_arb_prio #(
        .MAX_STREAK(MAX_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .mem_req  (mem_req),
        .grant_en (grant_en),
        .grant_if (grant_if),
        .grant_mem(grant_mem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_mem || grant_if) begin
                // Fetches are always full-word reads.
                owner_q <= grant_mem ? OWN_MEM : OWN_IF;
                addr_q  <= grant_mem ? mem_addr : if_addr;
                we_q    <= grant_mem & mem_we;
                sel_q   <= grant_mem ? mem_sel : '1;
                wdata_q <= grant_mem ? mem_wdata : '0;
                cnt_q   <= CNT_LOAD;
            end else if (state_q == ST_ACCESS) begin
                if (cnt_q == '0) begin
                    rdata_q <= we_q ? '0 : ram_rdata;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ram_ce    = CHIP_DISABLE;
        ram_we    = WRITE_DISABLE;
        if_ack    = 1'b0;
        mem_ack   = 1'b0;
        if_rdata  = '0;
        mem_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_mem || grant_if) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                ram_ce = CHIP_ENABLE;
                ram_we = we_q ? WRITE_ENABLE : WRITE_DISABLE;
                if (cnt_q == '0) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q == OWN_MEM) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_q;
                end else begin
                    if_ack   = 1'b1;
                    if_rdata = rdata_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_addr     = addr_q;
    assign ram_sel      = sel_q;
    assign ram_wdata    = wdata_q;
    assign stallreq_if  = if_req & ~if_ack;
    assign stallreq_mem = mem_req & ~mem_ack;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM_LAT 1 and 3) sharing inputs, each with its own RAM.
module tb_mem_arbiter;

    localparam int N_TXN = 16;
    localparam int MAXS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic        dsel;

    logic        if_ack_d[2], mem_ack_d[2], ram_ce_d[2], ram_we_d[2];
    logic        stall_if_d[2], stall_mem_d[2];
    logic [31:0] if_rdata_d[2], mem_rdata_d[2], ram_addr_d[2], ram_wdata_d[2], ram_rdata_d[2];
    logic [3:0]  ram_sel_d[2];
    logic [1:0]  dbg_state_d[2];

    logic [31:0] ram[2][16];
    logic        init_en, poke_en, poke_k;
    logic [3:0]  poke_idx;
    logic [31:0] poke_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] exp_if_q[$], exp_mem_q[$];
    int          exp_if_t[$], exp_mem_t[$];

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .MAX_STREAK(MAXS)) u_lat1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack_d[0]), .if_rdata(if_rdata_d[0]),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack_d[0]), .mem_rdata(mem_rdata_d[0]),
        .ram_ce(ram_ce_d[0]), .ram_we(ram_we_d[0]), .ram_addr(ram_addr_d[0]),
        .ram_sel(ram_sel_d[0]), .ram_wdata(ram_wdata_d[0]), .ram_rdata(ram_rdata_d[0]),
        .stallreq_if(stall_if_d[0]), .stallreq_mem(stall_mem_d[0]), .dbg_state(dbg_state_d[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .MAX_STREAK(MAXS)) u_lat3 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack_d[1]), .if_rdata(if_rdata_d[1]),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack_d[1]), .mem_rdata(mem_rdata_d[1]),
        .ram_ce(ram_ce_d[1]), .ram_we(ram_we_d[1]), .ram_addr(ram_addr_d[1]),
        .ram_sel(ram_sel_d[1]), .ram_wdata(ram_wdata_d[1]), .ram_rdata(ram_rdata_d[1]),
        .stallreq_if(stall_if_d[1]), .stallreq_mem(stall_mem_d[1]), .dbg_state(dbg_state_d[1])
    );

    function automatic logic [31:0] init_word(input int k, input int i);
        return 32'hC0DE_0000 + 32'(k * 4096) + 32'(i * 17);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // RAM models: combinational read, byte-enabled write while ce & we.
    assign ram_rdata_d[0] = ram[0][ram_addr_d[0][5:2]];
    assign ram_rdata_d[1] = ram[1][ram_addr_d[1][5:2]];

    always @(posedge clk) begin
        if (init_en) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 16; i++) ram[k][i] <= init_word(k, i);
        end else begin
            for (int k = 0; k < 2; k++)
                if (ram_ce_d[k] && ram_we_d[k])
                    ram[k][ram_addr_d[k][5:2]] <= merge(ram[k][ram_addr_d[k][5:2]],
                                                        ram_wdata_d[k], ram_sel_d[k]);
            if (poke_en) ram[poke_k][poke_idx] <= poke_data;
        end
    end

    // Outputs of the instance under test.
    logic        if_ack, mem_ack, ram_ce, ram_we, stallreq_if;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_sel;
    logic [1:0]  dbg_state;
    assign if_ack      = if_ack_d[dsel];
    assign mem_ack     = mem_ack_d[dsel];
    assign ram_ce      = ram_ce_d[dsel];
    assign ram_we      = ram_we_d[dsel];
    assign stallreq_if = stall_if_d[dsel];
    assign if_rdata    = if_rdata_d[dsel];
    assign mem_rdata   = mem_rdata_d[dsel];
    assign ram_addr    = ram_addr_d[dsel];
    assign ram_wdata   = ram_wdata_d[dsel];
    assign ram_sel     = ram_sel_d[dsel];
    assign dbg_state   = dbg_state_d[dsel];

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1; init_en = 1'b1; poke_en = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
        repeat (3) tick();
        rst = 1'b0; init_en = 1'b0;
    endtask

    task automatic poke(input logic k, input logic [3:0] idx, input logic [31:0] d);
        poke_en = 1'b1; poke_k = k; poke_idx = idx; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; init_en = 1'b1; poke_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h40; mem_req = 1'b1; mem_we = 1'b1;
        mem_addr = 32'h44; mem_sel = 4'hF; mem_wdata = 32'hFFFF_FFFF;
        repeat (2) tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({ram_ce_d[k], ram_we_d[k], if_ack_d[k], mem_ack_d[k]} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d] ce/we/if_ack/mem_ack=%b expected 0000", k,
                         {ram_ce_d[k], ram_we_d[k], if_ack_d[k], mem_ack_d[k]});
            end
            n_tests++;
            if ({ram_addr_d[k], ram_wdata_d[k], ram_sel_d[k], if_rdata_d[k], mem_rdata_d[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_data[%0d] addr=%h wdata=%h sel=%h if_rdata=%h mem_rdata=%h expected all 0",
                         k, ram_addr_d[k], ram_wdata_d[k], ram_sel_d[k], if_rdata_d[k], mem_rdata_d[k]);
            end
            n_tests++;
            if ({stall_if_d[k], stall_mem_d[k]} !== 2'b11) begin
                n_fail++;
                $display("FAIL reset_stall[%0d] got %b expected 11", k, {stall_if_d[k], stall_mem_d[k]});
            end
            n_tests++;
            if (dbg_state_d[k] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d] got %0d expected 0", k, dbg_state_d[k]);
            end
        end
        tick();
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        rst = 1'b0; init_en = 1'b0;
    endtask

    task automatic test_if_read();
        dsel = 1'b0;
        reset_all();
        poke(1'b0, 4'd4, 32'hDEAD_BEEF);
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (ram_ce !== (c == 1)) begin
                n_fail++; $display("FAIL if_read_ce c=%0d got %b expected %b", c, ram_ce, c == 1);
            end
            n_tests++;
            if (if_ack !== (c == 2)) begin
                n_fail++; $display("FAIL if_read_ack c=%0d got %b expected %b", c, if_ack, c == 2);
            end
            n_tests++;
            if (if_rdata !== ((c == 2) ? 32'hDEAD_BEEF : 32'h0)) begin
                n_fail++; $display("FAIL if_read_data c=%0d got %h", c, if_rdata);
            end
            if (c == 1) begin
                n_tests++;
                if ({ram_we, ram_sel, ram_addr} !== {1'b0, 4'hF, 32'h10}) begin
                    n_fail++;
                    $display("FAIL if_read_bus we=%b sel=%h addr=%h expected 0/f/10", ram_we, ram_sel, ram_addr);
                end
            end
            if (c == 3) begin
                n_tests++;
                if (ram_addr !== 32'h10) begin
                    n_fail++; $display("FAIL if_read_hold addr=%h expected 10", ram_addr);
                end
            end
            tick();
            if (c == 2) if_req = 1'b0;
        end
    endtask

    task automatic test_both_same_cycle();
        dsel = 1'b0;
        reset_all();
        if_req = 1'b1; if_addr = 32'h20;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h24;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests++;
            if ({mem_ack, if_ack} !== {c == 2, c == 5}) begin
                n_fail++;
                $display("FAIL both_acks c=%0d mem/if=%b expected %b", c, {mem_ack, if_ack}, {c == 2, c == 5});
            end
            n_tests++;
            if (stallreq_if !== (c < 5)) begin
                n_fail++; $display("FAIL both_stall_if c=%0d got %b expected %b", c, stallreq_if, c < 5);
            end
            if (c == 2) begin
                n_tests++;
                if (mem_rdata !== init_word(0, 9)) begin
                    n_fail++; $display("FAIL both_mem_data got %h expected %h", mem_rdata, init_word(0, 9));
                end
            end
            if (c == 5) begin
                n_tests++;
                if (if_rdata !== init_word(0, 8)) begin
                    n_fail++; $display("FAIL both_if_data got %h expected %h", if_rdata, init_word(0, 8));
                end
            end
            tick();
            if (c == 2) mem_req = 1'b0;
            if (c == 5) if_req = 1'b0;
        end
    endtask

    task automatic test_store_load();
        logic [31:0] w;
        logic        got;
        dsel = 1'b1;
        reset_all();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0C; mem_sel = 4'b0011; mem_wdata = 32'h1234_5678;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (ram_ce !== (c >= 1 && c <= 3)) begin
                n_fail++; $display("FAIL store_ce c=%0d got %b", c, ram_ce);
            end
            if (c >= 1 && c <= 3) begin
                n_tests++;
                if ({ram_we, ram_sel, ram_wdata, ram_addr} !== {1'b1, 4'b0011, 32'h1234_5678, 32'h0C}) begin
                    n_fail++;
                    $display("FAIL store_bus c=%0d we=%b sel=%b wdata=%h addr=%h", c, ram_we, ram_sel, ram_wdata, ram_addr);
                end
            end
            n_tests++;
            if (mem_ack !== (c == 4)) begin
                n_fail++; $display("FAIL store_ack c=%0d got %b expected %b", c, mem_ack, c == 4);
            end
            if (c == 4) begin
                n_tests++;
                if ({ram_we, mem_rdata} !== 33'h0) begin
                    n_fail++; $display("FAIL store_resp we=%b rdata=%h expected 0/0", ram_we, mem_rdata);
                end
            end
            tick();
            if (c == 4) begin mem_req = 1'b0; mem_we = 1'b0; end
        end
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0C;
        got = 1'b0;
        for (int wt = 0; wt < 20 && !got; wt++) begin
            @(negedge clk);
            if (mem_ack) got = 1'b1;
            else tick();
        end
        w = init_word(1, 3);
        n_tests++;
        if (!got || mem_rdata !== {w[31:16], 16'h5678}) begin
            n_fail++;
            $display("FAIL store_reload ack=%b got %h expected %h", got, mem_rdata, {w[31:16], 16'h5678});
        end
        tick();
        mem_req = 1'b0;
    endtask

    task automatic test_streak();
        int  k;
        logic ack_cyc;
        dsel = 1'b0;
        reset_all();
        if_req = 1'b1; if_addr = 32'h04;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h08;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            ack_cyc = (c >= 2) && ((c - 2) % 3 == 0);
            k = (c - 2) / 3;
            n_tests++;
            if ({if_ack, mem_ack} !== {ack_cyc && (k % 5 == 4), ack_cyc && (k % 5 != 4)}) begin
                n_fail++;
                $display("FAIL streak c=%0d if/mem=%b expected %b", c, {if_ack, mem_ack},
                         {ack_cyc && (k % 5 == 4), ack_cyc && (k % 5 != 4)});
            end
            tick();
        end
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    task automatic test_lat3_capture();
        dsel = 1'b1;
        reset_all();
        poke(1'b1, 4'd5, 32'hAAAA_5555);
        if_req = 1'b1; if_addr = 32'h14;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (ram_ce !== (c >= 1 && c <= 3)) begin
                n_fail++; $display("FAIL lat3_ce c=%0d got %b", c, ram_ce);
            end
            n_tests++;
            if (if_ack !== (c == 4)) begin
                n_fail++; $display("FAIL lat3_ack c=%0d got %b expected %b", c, if_ack, c == 4);
            end
            if (c == 4) begin
                n_tests++;
                if (if_rdata !== 32'hAAAA_5555) begin
                    n_fail++; $display("FAIL lat3_data got %h expected aaaa5555", if_rdata);
                end
            end
            if (c == 3) begin
                poke_en = 1'b1; poke_k = 1'b1; poke_idx = 4'd5; poke_data = 32'h5555_AAAA;
            end
            tick();
            poke_en = 1'b0;
            if (c == 4) if_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        dsel = 1'b1;
        reset_all();
        if_req = 1'b1; if_addr = 32'h18;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if (ram_ce !== ((c >= 1 && c <= 2) || (c >= 4 && c <= 6))) begin
                n_fail++; $display("FAIL rstmid_ce c=%0d got %b", c, ram_ce);
            end
            n_tests++;
            if (if_ack !== (c == 7)) begin
                n_fail++; $display("FAIL rstmid_ack c=%0d got %b expected %b", c, if_ack, c == 7);
            end
            if (c == 3) begin
                n_tests++;
                if (dbg_state !== 2'd0) begin
                    n_fail++; $display("FAIL rstmid_state got %0d expected 0", dbg_state);
                end
            end
            if (c == 7) begin
                n_tests++;
                if (if_rdata !== init_word(1, 6)) begin
                    n_fail++; $display("FAIL rstmid_data got %h expected %h", if_rdata, init_word(1, 6));
                end
            end
            tick();
            rst = (c == 1);
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_random(input logic which);
        int          gi[N_TXN], gm[N_TXN];
        logic [31:0] ia[N_TXN], ma[N_TXN], mw[N_TXN];
        logic        mwe[N_TXN];
        logic [3:0]  ms[N_TXN];
        logic [31:0] em[16];
        int lat, if_rdy, mem_rdy, ii, mi, t_free, d, streak, s0;
        logic pend_if, pend_mem;
        dsel = which;
        lat  = which ? 3 : 1;
        reset_all();
        for (int n = 0; n < N_TXN; n++) begin
            gi[n]  = $urandom_range(0, 3);
            gm[n]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            ia[n]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            ma[n]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            mw[n]  = $urandom;
            mwe[n] = 1'($urandom_range(0, 1));
            ms[n]  = 4'($urandom_range(1, 15));
        end
        // Transaction-level schedule: one access at a time, decided at the first free IDLE cycle.
        for (int i = 0; i < 16; i++) em[i] = init_word(which, i);
        exp_if_q.delete(); exp_mem_q.delete(); exp_if_t.delete(); exp_mem_t.delete();
        if_rdy = gi[0]; mem_rdy = gm[0]; ii = 0; mi = 0; t_free = 0; streak = 0;
        while (ii < N_TXN || mi < N_TXN) begin
            if (ii >= N_TXN) d = mem_rdy;
            else if (mi >= N_TXN) d = if_rdy;
            else d = (if_rdy < mem_rdy) ? if_rdy : mem_rdy;
            if (d < t_free) d = t_free;
            pend_if  = (ii < N_TXN) && (if_rdy <= d);
            pend_mem = (mi < N_TXN) && (mem_rdy <= d);
            if (pend_mem && (!pend_if || streak < MAXS)) begin
                streak = pend_if ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                exp_mem_t.push_back(d + lat + 1);
                if (mwe[mi]) begin
                    em[ma[mi][5:2]] = merge(em[ma[mi][5:2]], mw[mi], ms[mi]);
                    exp_mem_q.push_back(32'h0);
                end else begin
                    exp_mem_q.push_back(em[ma[mi][5:2]]);
                end
                mi++;
                if (mi < N_TXN) mem_rdy = d + lat + 2 + gm[mi];
            end else begin
                streak = 0;
                exp_if_t.push_back(d + lat + 1);
                exp_if_q.push_back(em[ia[ii][5:2]]);
                ii++;
                if (ii < N_TXN) if_rdy = d + lat + 2 + gi[ii];
            end
            t_free = d + lat + 2;
        end
        s0 = cyc;
        fork
            begin
                for (int n = 0; n < N_TXN; n++) begin
                    logic got;
                    int   et;
                    logic [31:0] ed;
                    if_req = 1'b0;
                    repeat (gi[n]) tick();
                    if_req = 1'b1; if_addr = ia[n];
                    got = 1'b0;
                    for (int w = 0; w < 300 && !got; w++) begin
                        @(negedge clk);
                        if (if_ack) got = 1'b1;
                        else tick();
                    end
                    et = exp_if_t.pop_front();
                    ed = exp_if_q.pop_front();
                    n_tests++;
                    if (!got || (cyc - s0) != et || if_rdata !== ed) begin
                        n_fail++;
                        $display("FAIL rand_if[%0d] lat=%0d ack=%b cycle=%0d data=%h expected cycle=%0d data=%h",
                                 n, lat, got, cyc - s0, if_rdata, et, ed);
                    end
                    tick();
                end
                if_req = 1'b0;
            end
            begin
                for (int n = 0; n < N_TXN; n++) begin
                    logic got;
                    int   et;
                    logic [31:0] ed;
                    mem_req = 1'b0;
                    repeat (gm[n]) tick();
                    mem_req = 1'b1; mem_addr = ma[n]; mem_we = mwe[n]; mem_sel = ms[n]; mem_wdata = mw[n];
                    got = 1'b0;
                    for (int w = 0; w < 300 && !got; w++) begin
                        @(negedge clk);
                        if (mem_ack) got = 1'b1;
                        else tick();
                    end
                    et = exp_mem_t.pop_front();
                    ed = exp_mem_q.pop_front();
                    n_tests++;
                    if (!got || (cyc - s0) != et || mem_rdata !== ed) begin
                        n_fail++;
                        $display("FAIL rand_mem[%0d] lat=%0d we=%b ack=%b cycle=%0d data=%h expected cycle=%0d data=%h",
                                 n, lat, mwe[n], got, cyc - s0, mem_rdata, et, ed);
                    end
                    tick();
                end
                mem_req = 1'b0; mem_we = 1'b0;
            end
        join
    endtask

    initial begin
        dsel = 1'b0;
        poke_en = 1'b0; poke_k = 1'b0; poke_idx = '0; poke_data = '0;
        test_reset();
        test_if_read();
        test_both_same_cycle();
        test_store_load();
        test_streak();
        test_lat3_capture();
        test_reset_mid_access();
        test_random(1'b0);
        test_random(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
